// File: rtl/mips_div_unit.sv
// mips_div_unit: multi-cycle radix-2 restoring divider for the EX stage.
//
// The EX stage raises div_start_i with the operands and holds it high. The unit
// produces one quotient bit per cycle. When it finishes it raises div_ready_o
// with div_result_o = {remainder, quotient}. These two halves go to HI and LO.
// EX releases its stall on ready and drops start. The unit then returns to IDLE
// and clears its outputs.
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-low reset
//   signed_div_i    1 = DIV (signed), 0 = DIVU (unsigned)
//   div_op_data1_i  dividend
//   div_op_data2_i  divisor
//   div_start_i     request level, held by EX until ready is seen
//   annul_i         pipeline flush, aborts any divide in progress
//   div_result_o    {remainder, quotient}, registered
//   div_ready_o     result valid, registered
module mips_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [DATA_WIDTH-1:0]     div_op_data1_i,
  input  logic [DATA_WIDTH-1:0]     div_op_data2_i,
  input  logic                      div_start_i,
  input  logic                      annul_i,
  output logic [2*DATA_WIDTH-1:0]   div_result_o,
  output logic                      div_ready_o
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   dvd;      // dividend magnitude, shifted out MSB first
  logic [DW-1:0]   dvs;      // divisor magnitude
  logic [DW-1:0]   rem;      // partial remainder (always < dvs)
  logic [DW-1:0]   quo;      // quotient bits, shifted in LSB first
  logic            sign_q;
  logic            sign_r;

  logic            req;
  logic            abort;
  logic [DW-1:0]   abs_a, abs_b;
  logic [DW:0]     trial;
  logic [DW-1:0]   q_fin, r_fin;

  assign req   = div_start_i && !annul_i;
  assign abort = annul_i || !div_start_i;

  // Operand magnitudes. The most negative value negates to itself. As an
  // unsigned magnitude it is still correct (2^(DW-1)).
  always_comb begin
    abs_a = div_op_data1_i;
    abs_b = div_op_data2_i;
    if (signed_div_i && div_op_data1_i[DW-1]) abs_a = -div_op_data1_i;
    if (signed_div_i && div_op_data2_i[DW-1]) abs_b = -div_op_data2_i;
  end

  // Trial subtraction of the divisor from the remainder, with the next dividend
  // bit shifted in. A clear MSB means the result is non-negative, so the
  // quotient bit is 1.
  assign trial = {rem, dvd[DW-1]} - {1'b0, dvs};

  assign q_fin = sign_q ? -quo : quo;
  assign r_fin = sign_r ? -rem : rem;

  // Next-state logic.
  // ON runs DW iteration cycles (cnt 0..DW-1) and then one finalize cycle
  // (cnt == DW) that applies the signs.
  // DIVZERO waits two cycles so that ready appears at the same offset that EX
  // expects for a zero divisor.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) state_nxt = (div_op_data2_i == '0) ? S_DIVZERO : S_ON;
      end
      S_DIVZERO: begin
        if (cnt == CW'(1)) state_nxt = S_END;
      end
      S_ON: begin
        if (abort)                state_nxt = S_IDLE;
        else if (cnt == CW'(DW))  state_nxt = S_END;
      end
      S_END: begin
        if (abort) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      dvd          <= '0;
      dvs          <= '0;
      rem          <= '0;
      quo          <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      div_result_o <= '0;
      div_ready_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          div_result_o <= '0;
          div_ready_o  <= 1'b0;
          cnt          <= '0;
          if (req && div_op_data2_i != '0) begin
            dvd    <= abs_a;
            dvs    <= abs_b;
            rem    <= '0;
            quo    <= '0;
            sign_q <= signed_div_i && (div_op_data1_i[DW-1] ^ div_op_data2_i[DW-1]);
            sign_r <= signed_div_i && div_op_data1_i[DW-1];
          end
        end

        S_DIVZERO: begin
          cnt <= cnt + CW'(1);
          if (state_nxt == S_END) begin
            div_result_o <= '0;
            div_ready_o  <= 1'b1;
          end
        end

        S_ON: begin
          if (abort) begin
            div_result_o <= '0;
            div_ready_o  <= 1'b0;
          end else if (cnt == CW'(DW)) begin
            div_result_o <= {r_fin, q_fin};
            div_ready_o  <= 1'b1;
          end else begin
            rem <= trial[DW] ? {rem[DW-2:0], dvd[DW-1]} : trial[DW-1:0];
            quo <= {quo[DW-2:0], ~trial[DW]};
            dvd <= {dvd[DW-2:0], 1'b0};
            cnt <= cnt + CW'(1);
          end
        end

        S_END: begin
          if (abort) begin
            div_result_o <= '0;
            div_ready_o  <= 1'b0;
          end
        end

        default: begin
          div_result_o <= '0;
          div_ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit.
// The driver issues divides and pushes the expected result and latency into a
// scoreboard queue. A monitor running on the falling edge pops an entry on each
// rising edge of ready and compares it.
module tb_mips_div_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          signed_div_i = 1'b0;
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] d2 = '0;
  logic          div_start_i = 1'b0;
  logic          annul_i = 1'b0;
  logic [2*DW-1:0] res;
  logic          rdy;

  mips_div_unit #(.DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .signed_div_i   (signed_div_i),
    .div_op_data1_i (d1),
    .div_op_data2_i (d2),
    .div_start_i    (div_start_i),
    .annul_i        (annul_i),
    .div_result_o   (res),
    .div_ready_o    (rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          start_edge;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model: plain integer division on magnitudes. Division truncates
  // toward zero, and the remainder takes the dividend's sign. A zero divisor
  // gives 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // Monitor
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rdy && !prev_rdy) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_ready: ready=1 with no request outstanding (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result", res, e.res);
        check("latency", 64'(cyc - e.start_edge), 64'(e.lat));
      end
    end
    prev_rdy = rdy;
  end

  // This task issues one divide and waits for ready. It holds start for `hold`
  // extra cycles and then either drops start or, if end_annul is set, raises
  // annul with start still high.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic [63:0] expv, input int hold, input bit end_annul);
    exp_t e;
    bit   got;
    e.res = expv;
    e.lat = (b == 0) ? 2 : 33;
    e.start_edge = cyc + 1;
    exp_q.push_back(e);
    d1 = a; d2 = b; signed_div_i = sg; div_start_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        // After the start edge, operand changes must not affect the result.
        d1 = $urandom; d2 = $urandom; signed_div_i = 1'($urandom_range(0, 1));
      end
      if (rdy) got = 1'b1;
    end
    if (!got) begin
      n_tot++;
      $display("FAIL ready_timeout: ready=0 expected 1 within 100 cycles (a=%h b=%h)", a, b);
      void'(exp_q.pop_back());
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_ready", 64'(rdy), 64'd1);
      check("hold_result", res, expv);
    end
    if (end_annul) annul_i = 1'b1;
    else           div_start_i = 1'b0;
    @(posedge clk); #1;
    check(end_annul ? "annul_end_ready" : "drop_ready", 64'(rdy), 64'd0);
    check(end_annul ? "annul_end_result" : "drop_result", res, 64'd0);
    annul_i = 1'b0;
    div_start_i = 1'b0;
  endtask

  // This task starts a divide and aborts it at iteration `at`, using either
  // annul or a start drop.
  task automatic abort_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           input int at, input bit use_annul);
    d1 = a; d2 = b; signed_div_i = sg; div_start_i = 1'b1;
    repeat (at + 1) @(posedge clk);
    #1;
    if (use_annul) annul_i = 1'b1;
    else           div_start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    div_start_i = 1'b0;
    check("abort_ready", 64'(rdy), 64'd0);
    check("abort_result", res, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    logic [31:0] a, b;
    logic sg;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(rdy), 64'd0);
    check("reset_result", res, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases; expected values written out by hand
    run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0, 1'b0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 1'b0);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 0, 1'b0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 0, 1'b0);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, 0, 1'b0);
    run_div(32'd1234, 32'd0, 1'b0, 64'd0, 4, 1'b0);
    run_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 3, 1'b0);
    run_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 2, 1'b1);

    // Abort by annul, then a new request one cycle later
    abort_div(32'd12345, 32'd17, 1'b0, 10, 1'b1);
    @(posedge clk); #1;
    run_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 0, 1'b0);
    // Abort by dropping start
    abort_div(32'd12345, 32'd17, 1'b1, 10, 1'b0);
    @(posedge clk); #1;
    run_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 0, 1'b0);

    // annul together with start in IDLE: annul wins
    annul_i = 1'b1; div_start_i = 1'b1; d1 = 32'd99; d2 = 32'd3; signed_div_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (rdy) seen = 1'b1; end
    check("annul_idle_no_ready", 64'(seen), 64'd0);
    annul_i = 1'b0; div_start_i = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a divide
    d1 = 32'd123456; d2 = 32'd789; signed_div_i = 1'b0; div_start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b0; div_start_i = 1'b0;
    @(posedge clk); #1;
    check("midreset_ready", 64'(rdy), 64'd0);
    check("midreset_result", res, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_div(32'd9, 32'd4, 1'b0, {32'd1, 32'd2}, 0, 1'b0);

    // Random divides checked against the model
    for (int n = 0; n < 16; n++) begin
      a  = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      sg = 1'($urandom_range(0, 1));
      run_div(a, b, sg, model(a, b, sg), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
